pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. Owns stall/flush control of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Runs the multi-cycle data-memory handshake for the instruction held in the EX/MEM register. Detects load-use hazards and applies taken-branch flushes with fixed priority.

---
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Data-memory bus handshake between the pipeline controller (master) and
// the data-memory port (slave).
//
// Handshake: the master raises bus_req and holds it, together with bus_we,
// until the slave answers with bus_ack (transfer complete) or bus_err
// (transfer failed). Both answers are sampled only while bus_req is high;
// bus_err takes precedence when both arrive in the same cycle. bus_req
// falls in the cycle after the answer.
interface pipe_ctrl_if;
    logic bus_req;
    logic bus_we;
    logic bus_ack;
    logic bus_err;

    modport master (
        output bus_req,
        output bus_we,
        input  bus_ack,
        input  bus_err
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        output bus_ack,
        output bus_err
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Owns stall/flush control of IF/ID, ID/EX, EX/MEM and MEM/WB, runs the
// multi-cycle data-memory handshake for the op held in EX/MEM, detects
// load-use hazards and applies taken-branch flushes.
// Priority: memory stall > bus fault > taken branch > load-use.
// Optional build macro PIPE_CTRL_PERF_EN adds 32-bit stall counters; when
// undefined the perf outputs are tied to zero.
// o_dbg_state exposes the handshake FSM state (IDLE=0, REQ=1, DONE=2, ERR=3).
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif

module pipe_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [`REG_ADDR_W-1:0] rs_addr_id,
    input  logic [`REG_ADDR_W-1:0] rt_addr_id,
    input  logic                   rs_used_id,
    input  logic                   rt_used_id,
    input  logic                   mem_to_reg_ex,
    input  logic                   reg_write_ex,
    input  logic [`REG_ADDR_W-1:0] dst_addr_ex,
    input  logic                   branch_taken_ex,
    input  logic                   mem_to_reg_mem,
    input  logic                   mem_write_mem,
    pipe_ctrl_if.master            bus,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   stall_ex,
    output logic                   flush_id,
    output logic                   flush_ex,
    output logic                   bubble_wb,
    output logic                   mem_fault,
    output logic [31:0]            perf_mem_stall,
    output logic [31:0]            perf_lu_stall,
    output logic [1:0]             o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Counter value seen on the last allowed REQ cycle; unused when TIMEOUT=0.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit               LP_TO_EN    = (TIMEOUT != 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_bus_req;
    logic             r_bus_we;
    logic             w_bus_we_nxt;
    logic             r_mem_fault;

    logic w_mem_op;
    logic w_mem_stall;
    logic w_err;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_use;

    assign w_mem_op    = mem_to_reg_mem | mem_write_mem;
    assign w_mem_stall = w_mem_op & ((r_state == ST_IDLE) | (r_state == ST_REQ));
    assign w_err       = (r_state == ST_ERR);
    assign w_rs_hit    = rs_used_id & (rs_addr_id == dst_addr_ex);
    assign w_rt_hit    = rt_used_id & (rt_addr_id == dst_addr_ex);
    assign w_load_use  = mem_to_reg_ex & reg_write_ex & (dst_addr_ex != '0) & (w_rs_hit | w_rt_hit);

    assign bus.bus_req = r_bus_req;
    assign bus.bus_we  = r_bus_we;
    assign mem_fault   = r_mem_fault;
    assign o_dbg_state = r_state;

    // Handshake state, timeout counter and registered bus/fault outputs.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bus_req   <= (w_state_nxt == ST_REQ);
            r_bus_we    <= w_bus_we_nxt;
            r_mem_fault <= (w_state_nxt == ST_ERR);
        end
    end

    // Next-state logic: bus error beats ack, ack beats timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bus_we_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    w_state_nxt  = ST_REQ;
                    w_cnt_nxt    = '0;
                    w_bus_we_nxt = mem_write_mem;
                end
            end
            ST_REQ: begin
                if (bus.bus_err) begin
                    w_state_nxt = ST_ERR;
                end else if (bus.bus_ack) begin
                    w_state_nxt = ST_DONE;
                end else if (LP_TO_EN && (r_cnt == LP_CNT_LAST)) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_cnt_nxt    = r_cnt + CNT_W'(1);
                    w_bus_we_nxt = r_bus_we;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pipeline control with fixed priority; a branch held in EX during a
    // memory stall is applied once the stall releases.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        bubble_wb = 1'b0;
        if (w_mem_stall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            bubble_wb = 1'b1;
        end else if (w_err) begin
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            bubble_wb = 1'b1;
        end else if (branch_taken_ex) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (w_load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_mem;
    logic [31:0] r_perf_lu;
    logic        w_lu_win;

    assign w_lu_win       = w_load_use & ~w_mem_stall & ~w_err & ~branch_taken_ex;
    assign perf_mem_stall = r_perf_mem;
    assign perf_lu_stall  = r_perf_lu;

    // Free-running stall counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_perf_mem <= '0;
            r_perf_lu  <= '0;
        end else begin
            r_perf_mem <= r_perf_mem + 32'(w_mem_stall);
            r_perf_lu  <= r_perf_lu + 32'(w_lu_win);
        end
    end
`else
    assign perf_mem_stall = '0;
    assign perf_lu_stall  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif

module tb_pipe_ctrl;
  localparam int TO = 4;
  localparam int AW = `REG_ADDR_W;

  logic clk = 1'b0;
  logic reset_;
  logic [AW-1:0] rs_addr_id, rt_addr_id, dst_addr_ex;
  logic rs_used_id, rt_used_id, mem_to_reg_ex, reg_write_ex, branch_taken_ex;
  logic mem_to_reg_mem, mem_write_mem, tb_ack, tb_err;

  logic stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_wb, mem_fault;
  logic [31:0] perf_mem_stall, perf_lu_stall;
  logic [1:0] dbg_state;

  logic b_stall_if, b_stall_id, b_stall_ex, b_flush_id, b_flush_ex, b_bubble_wb, b_mem_fault;
  logic [31:0] b_perf_mem, b_perf_lu;
  logic [1:0] b_dbg_state;

  pipe_ctrl_if bus_a ();
  pipe_ctrl_if bus_b ();
  assign bus_a.bus_ack = tb_ack;
  assign bus_a.bus_err = tb_err;
  assign bus_b.bus_ack = tb_ack;
  assign bus_b.bus_err = tb_err;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(TO), .CNT_W(3)) u_dut (
    .clk(clk), .reset_(reset_),
    .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .mem_to_reg_ex(mem_to_reg_ex), .reg_write_ex(reg_write_ex),
    .dst_addr_ex(dst_addr_ex), .branch_taken_ex(branch_taken_ex),
    .mem_to_reg_mem(mem_to_reg_mem), .mem_write_mem(mem_write_mem),
    .bus(bus_a.master),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .bubble_wb(bubble_wb),
    .mem_fault(mem_fault), .perf_mem_stall(perf_mem_stall),
    .perf_lu_stall(perf_lu_stall), .o_dbg_state(dbg_state)
  );

  // Second instance with the timeout disabled.
  pipe_ctrl #(.TIMEOUT(0), .CNT_W(5)) u_dut_nto (
    .clk(clk), .reset_(reset_),
    .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
    .mem_to_reg_ex(mem_to_reg_ex), .reg_write_ex(reg_write_ex),
    .dst_addr_ex(dst_addr_ex), .branch_taken_ex(branch_taken_ex),
    .mem_to_reg_mem(mem_to_reg_mem), .mem_write_mem(mem_write_mem),
    .bus(bus_b.master),
    .stall_if(b_stall_if), .stall_id(b_stall_id), .stall_ex(b_stall_ex),
    .flush_id(b_flush_id), .flush_ex(b_flush_ex), .bubble_wb(b_bubble_wb),
    .mem_fault(b_mem_fault), .perf_mem_stall(b_perf_mem),
    .perf_lu_stall(b_perf_lu), .o_dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one outstanding memory transaction.
  bit          m_req;       // request on the bus
  bit          m_we;
  int          m_cnt;       // REQ cycles already spent without an answer
  int          m_post;      // 0 none, 1 completed (advance cycle), 2 fault cycle
  logic [31:0] m_perf_mem, m_perf_lu;
  bit          c_ms, c_luwin;

  // Observation counters for scenario-level checks.
  int n_req_hi, n_sex, n_fault, n_breq, n_bfault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_we = 0; m_cnt = 0; m_post = 0;
    m_perf_mem = '0; m_perf_lu = '0;
  endtask

  task automatic clr_in();
    rs_addr_id = '0; rt_addr_id = '0; dst_addr_ex = '0;
    rs_used_id = 0; rt_used_id = 0; mem_to_reg_ex = 0; reg_write_ex = 0;
    branch_taken_ex = 0; mem_to_reg_mem = 0; mem_write_mem = 0;
    tb_ack = 0; tb_err = 0;
  endtask

  task automatic zero_obs();
    n_req_hi = 0; n_sex = 0; n_fault = 0; n_breq = 0; n_bfault = 0;
  endtask

  // Compare every output of the checked instance with the model's prediction.
  task automatic check_outputs();
    bit mem_op, idle, ms, er, lu;
    bit e_sif, e_sid, e_sex, e_fid, e_fex, e_bwb;
    mem_op = mem_to_reg_mem || mem_write_mem;
    idle   = !m_req && (m_post == 0);
    ms     = mem_op && (idle || m_req);
    er     = (m_post == 2);
    lu     = mem_to_reg_ex && reg_write_ex && (dst_addr_ex != 0) &&
             ((rs_used_id && rs_addr_id == dst_addr_ex) || (rt_used_id && rt_addr_id == dst_addr_ex));
    e_sif = 0; e_sid = 0; e_sex = 0; e_fid = 0; e_fex = 0; e_bwb = 0;
    if (ms) begin
      e_sif = 1; e_sid = 1; e_sex = 1; e_bwb = 1;
    end else if (er) begin
      e_fid = 1; e_fex = 1; e_bwb = 1;
    end else if (branch_taken_ex) begin
      e_fid = 1; e_fex = 1;
    end else if (lu) begin
      e_sif = 1; e_sid = 1; e_fex = 1;
    end
    c_ms    = ms;
    c_luwin = lu && !ms && !er && !branch_taken_ex;
    chk("bus_req", bus_a.bus_req, m_req);
    if (m_req) chk("bus_we", bus_a.bus_we, m_we);
    chk("mem_fault", mem_fault, er);
    chk("stall_if", stall_if, e_sif);
    chk("stall_id", stall_id, e_sid);
    chk("stall_ex", stall_ex, e_sex);
    chk("flush_id", flush_id, e_fid);
    chk("flush_ex", flush_ex, e_fex);
    chk("bubble_wb", bubble_wb, e_bwb);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_mem", perf_mem_stall, m_perf_mem);
    chk("perf_lu", perf_lu_stall, m_perf_lu);
`else
    chk("perf_mem_off", perf_mem_stall, 32'd0);
    chk("perf_lu_off", perf_lu_stall, 32'd0);
`endif
    if (bus_a.bus_req) n_req_hi++;
    if (stall_ex) n_sex++;
    if (mem_fault) n_fault++;
    if (bus_b.bus_req) n_breq++;
    if (b_mem_fault) n_bfault++;
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_update();
    m_perf_mem = m_perf_mem + 32'(c_ms);
    m_perf_lu  = m_perf_lu + 32'(c_luwin);
    if (m_post != 0) begin
      m_post = 0;
    end else if (m_req) begin
      if (tb_err) begin
        m_req = 0; m_post = 2;
      end else if (tb_ack) begin
        m_req = 0; m_post = 1;
      end else if (TO != 0 && m_cnt + 1 == TO) begin
        m_req = 0; m_post = 2;
      end else begin
        m_cnt++;
      end
    end else if (mem_to_reg_mem || mem_write_mem) begin
      m_req = 1; m_we = mem_write_mem; m_cnt = 0;
    end
  endtask

  // Inputs are set at posedge+1; outputs sampled mid-cycle.
  task automatic step();
    #2;
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] perf0;
    clr_in();
    model_reset();
    reset_ = 1'b0;
    #3;
    chk("rst_bus_req", bus_a.bus_req, 1'b0);
    chk("rst_bus_we", bus_a.bus_we, 1'b0);
    chk("rst_fault", mem_fault, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_perf", perf_mem_stall, 32'd0);
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    step();

    // Load, ack on the second REQ cycle.
    zero_obs();
    mem_to_reg_mem = 1;
    step(); step();
    tb_ack = 1; step();
    tb_ack = 0; step();
    mem_to_reg_mem = 0; step();
    chk("s1_req_cycles", n_req_hi, 2);
    chk("s1_stall_ex_cycles", n_sex, 3);

    // Load acknowledged on the first REQ cycle: two stall cycles.
    perf0 = perf_mem_stall;
    mem_to_reg_mem = 1; step();
    tb_ack = 1; step();
    tb_ack = 0; step();
    mem_to_reg_mem = 0; step();
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_3cyc_load", perf_mem_stall - perf0, 32'd2);
`else
    chk("perf_3cyc_load", perf_mem_stall - perf0, 32'd0);
`endif

    // Store with ack and err together: error wins.
    zero_obs();
    mem_write_mem = 1; step();
    #2; chk("s2_we", bus_a.bus_we, 1'b1); #1;
    tb_ack = 1; tb_err = 1; step();
    tb_ack = 0; tb_err = 0; step();
    mem_write_mem = 0; step();
    chk("s2_fault_pulses", n_fault, 1);

    // Timeout: no answer. The checked instance faults after 4 REQ cycles,
    // the timeout-free instance keeps requesting.
    zero_obs();
    mem_to_reg_mem = 1;
    for (int i = 0; i < 6; i++) step();
    chk("s3_req_cycles", n_req_hi, TO);
    chk("s3_fault_pulses", n_fault, 1);
    zero_obs();
    for (int i = 0; i < 30; i++) step();
    chk("s3_nto_req_held", n_breq, 30);
    chk("s3_nto_no_fault", n_bfault, 0);
    tb_ack = 1; mem_to_reg_mem = 0; step();
    tb_ack = 0;
    for (int i = 0; i < 8; i++) step();
    #2; chk("s3_nto_released", bus_b.bus_req, 1'b0); #1;

    // Load-use on rt, then the same with r0 as destination.
    mem_to_reg_ex = 1; reg_write_ex = 1; dst_addr_ex = AW'(5);
    rt_used_id = 1; rt_addr_id = AW'(5);
    #2; chk("lu_stall_if", stall_if, 1'b1); chk("lu_flush_ex", flush_ex, 1'b1);
    chk("lu_stall_ex", stall_ex, 1'b0); #1;
    step();
    dst_addr_ex = '0; rt_addr_id = '0;
    #2; chk("lu_r0_no_stall", stall_if, 1'b0); #1;
    step();
    clr_in(); step();

    // Taken branch frozen during a memory stall, applied in the advance cycle.
    mem_to_reg_mem = 1; branch_taken_ex = 1;
    #2; chk("br_held_flush", flush_id, 1'b0); #1;
    step();
    tb_ack = 1; step();
    tb_ack = 0;
    #2; chk("br_done_flush_id", flush_id, 1'b1); chk("br_done_flush_ex", flush_ex, 1'b1); #1;
    step();
    clr_in(); step();

    // Asynchronous reset in the middle of a request.
    mem_to_reg_mem = 1; step();
    #2; chk("rst_mid_pre", bus_a.bus_req, 1'b1);
    reset_ = 1'b0;
    #1;
    chk("rst_mid_req", bus_a.bus_req, 1'b0);
    chk("rst_mid_fault", mem_fault, 1'b0);
    chk("rst_mid_state", dbg_state, 2'd0);
    chk("rst_mid_stall", stall_ex, 1'b1);
    model_reset();
    clr_in();
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mem_to_reg_mem = 1'($urandom_range(0, 1));
        mem_write_mem  = mem_to_reg_mem ? 1'b0 : 1'($urandom_range(0, 1));
      end
      tb_ack          = ($urandom_range(0, 2) == 0);
      tb_err          = ($urandom_range(0, 15) == 0);
      branch_taken_ex = ($urandom_range(0, 7) == 0);
      mem_to_reg_ex   = 1'($urandom_range(0, 1));
      reg_write_ex    = ($urandom_range(0, 3) != 0);
      dst_addr_ex     = AW'($urandom_range(0, 3));
      rs_addr_id      = AW'($urandom_range(0, 3));
      rt_addr_id      = AW'($urandom_range(0, 3));
      rs_used_id      = 1'($urandom_range(0, 1));
      rt_used_id      = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
